// File: rtl/ysyx_220066_mdu.sv
// Iterative RV64M multiply/divide: one radix-2 step per cycle, N+1 cycles from accept (1 for div special cases).
// One op in flight; in_ready only in IDLE, result held in DONE until out_ready; flush/rst abort silently.
module ysyx_220066_mdu #(
  parameter int XLEN    = 64,
  parameter bit WORD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  localparam int CW   = $clog2(XLEN);
  localparam bit W_OK = WORD_EN && (XLEN > 32);
  localparam int SH   = (XLEN > 32) ? XLEN - 32 : 0;
  localparam logic [CW-1:0] LAST_D = CW'(XLEN - 1);
  localparam logic [CW-1:0] LAST_W = CW'(31);

  state_t          r_state, w_state_nx;
  logic [XLEN-1:0] r_hi, r_lo, r_b, r_result;
  logic [CW-1:0]   r_iter;
  logic [2:0]      r_op;
  logic            r_word, r_neg_q, r_neg_r;

  // ---------------- request decode ----------------
  logic            w_accept, w_word, w_is_div, w_sgn_a, w_sgn_b;
  logic [2:0]      w_op;
  logic [31:0]     w_a32, w_b32;
  logic [XLEN-1:0] w_a_x, w_b_x, w_a_sx, w_mag_a, w_mag_b, w_spec_res;
  logic            w_neg_a, w_neg_b, w_b_zero, w_a_min, w_ovf, w_special;

  assign w_accept = in_valid && (r_state == S_IDLE) && !flush;
  assign w_word   = W_OK && word;
  // MULHW/MULHSUW/MULHUW do not exist; word forms of ops 1..3 collapse to MULW
  assign w_op     = (w_word && !op[2] && (op[1:0] != 2'd0)) ? 3'd0 : op;
  assign w_is_div = w_op[2];
  assign w_sgn_a  = (w_op != 3'd3) && (w_op != 3'd5) && (w_op != 3'd7);
  assign w_sgn_b  = w_sgn_a && (w_op != 3'd2);

  assign w_a32  = 32'(src_a);
  assign w_b32  = 32'(src_b);
  assign w_a_x  = w_word ? (w_sgn_a ? XLEN'($signed(w_a32)) : XLEN'(w_a32)) : src_a;
  assign w_b_x  = w_word ? (w_sgn_b ? XLEN'($signed(w_b32)) : XLEN'(w_b32)) : src_b;
  assign w_a_sx = w_word ? XLEN'($signed(w_a32)) : src_a;

  assign w_neg_a = w_sgn_a && (w_word ? w_a32[31] : src_a[XLEN-1]);
  assign w_neg_b = w_sgn_b && (w_word ? w_b32[31] : src_b[XLEN-1]);
  assign w_mag_a = w_neg_a ? -w_a_x : w_a_x;
  assign w_mag_b = w_neg_b ? -w_b_x : w_b_x;

  assign w_b_zero  = (w_b_x == '0);
  assign w_a_min   = w_word ? (w_a32 == 32'h8000_0000) : (src_a == {1'b1, {(XLEN-1){1'b0}}});
  assign w_ovf     = w_sgn_a && w_a_min && (w_b_x == '1);
  assign w_special = w_is_div && (w_b_zero || w_ovf);
  assign w_spec_res = w_op[1] ? (w_b_zero ? w_a_sx : '0) : (w_b_zero ? '1 : w_a_sx);

  // ---------------- iteration datapath ----------------
  logic [XLEN:0]     w_sum, w_shd, w_diff;
  logic              w_ge, w_last;
  logic [XLEN-1:0]   w_hi_nx, w_lo_nx, w_q, w_r, w_dr, w_fin;
  logic [2*XLEN-1:0] w_prod, w_prod_s;
  logic [31:0]       w_p32, w_p32_s;

  assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_shd  = {r_hi, r_lo[XLEN-1]};
  assign w_diff = w_shd - {1'b0, r_b};
  assign w_ge   = !w_diff[XLEN];

  assign w_hi_nx = r_op[2] ? (w_ge ? w_diff[XLEN-1:0] : w_shd[XLEN-1:0]) : w_sum[XLEN:1];
  assign w_lo_nx = r_op[2] ? {r_lo[XLEN-2:0], w_ge} : {w_sum[0], r_lo[XLEN-1:1]};
  assign w_last  = (r_iter == (r_word ? LAST_W : LAST_D));

  assign w_prod   = {w_hi_nx, w_lo_nx};
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;
  // word products finish shifted up by XLEN-32, so the low word sits at the top of r_lo
  assign w_p32    = 32'(w_lo_nx >> SH);
  assign w_p32_s  = r_neg_q ? -w_p32 : w_p32;
  assign w_q      = r_neg_q ? -w_lo_nx : w_lo_nx;
  assign w_r      = r_neg_r ? -w_hi_nx : w_hi_nx;
  assign w_dr     = r_op[1] ? w_r : w_q;

  always_comb begin
    w_fin = '0;
    if (r_op[2])
      w_fin = r_word ? XLEN'($signed(32'(w_dr))) : w_dr;
    else if (r_word)
      w_fin = XLEN'($signed(w_p32_s));
    else if (r_op[1:0] == 2'd0)
      w_fin = w_prod_s[XLEN-1:0];
    else
      w_fin = w_prod_s[2*XLEN-1:XLEN];
  end

  // ---------------- control ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_state_nx = w_special ? S_DONE : S_CALC;
      S_CALC: if (w_last) w_state_nx = S_DONE;
      S_DONE: if (out_ready) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
    if (flush) w_state_nx = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_iter   <= '0;
      r_op     <= '0;
      r_word   <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_op    <= w_op;
        r_word  <= w_word;
        r_iter  <= '0;
        r_hi    <= '0;
        // dividend is left-aligned so both widths consume it MSB-first
        r_lo    <= w_is_div ? (w_word ? (w_mag_a << SH) : w_mag_a) : w_mag_a;
        r_b     <= w_mag_b;
        r_neg_q <= w_neg_a ^ w_neg_b;
        r_neg_r <= w_neg_a;
        if (w_special) r_result <= w_spec_res;
      end
      if (r_state == S_CALC) begin
        r_hi   <= w_hi_nx;
        r_lo   <= w_lo_nx;
        r_iter <= r_iter + 1'b1;
        if (w_last) r_result <= w_fin;
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign result    = r_result;

endmodule

// File: tb/tb_ysyx_220066_mdu.sv
// Scoreboard bench for ysyx_220066_mdu: expected result and latency queued at drive, compared at out_valid.
module tb_ysyx_220066_mdu;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, word, out_valid, out_ready, busy;
  logic [2:0]  op;
  logic [63:0] src_a, src_b, result;

  int n_chk = 0;
  int n_err = 0;
  logic [63:0] q_exp[$];
  int          q_lat[$];

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  ysyx_220066_mdu #(.XLEN(64), .WORD_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .word(word), .src_a(src_a), .src_b(src_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mdu(input logic [2:0] o, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [31:0] a32, b32, r32;
    logic signed [127:0] pa, pb, p;
    logic [63:0] r;
    a32 = a[31:0]; b32 = b[31:0]; r32 = '0; r = '0;
    pa = '0; pb = '0; p = '0;
    if (w) begin
      case (o)
        3'd4: if (b32 == 0) r32 = '1;
              else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = a32;
              else r32 = $signed(a32) / $signed(b32);
        3'd5: if (b32 == 0) r32 = '1; else r32 = a32 / b32;
        3'd6: if (b32 == 0) r32 = a32;
              else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = '0;
              else r32 = $signed(a32) % $signed(b32);
        3'd7: if (b32 == 0) r32 = a32; else r32 = a32 % b32;
        default: r32 = a32 * b32;
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      case (o)
        3'd0: r = a * b;
        3'd1: begin pa = {{64{a[63]}}, a}; pb = {{64{b[63]}}, b}; p = pa * pb; r = p[127:64]; end
        3'd2: begin pa = {{64{a[63]}}, a}; pb = {64'd0, b};       p = pa * pb; r = p[127:64]; end
        3'd3: begin pa = {64'd0, a};       pb = {64'd0, b};       p = pa * pb; r = p[127:64]; end
        3'd4: if (b == 0) r = ONES; else if (a == MINV && b == ONES) r = a;
              else r = $signed(a) / $signed(b);
        3'd5: if (b == 0) r = ONES; else r = a / b;
        3'd6: if (b == 0) r = a; else if (a == MINV && b == ONES) r = '0;
              else r = $signed(a) % $signed(b);
        default: if (b == 0) r = a; else r = a % b;
      endcase
    end
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    logic sgn, zero, ovf;
    sgn  = (o == 3'd4) || (o == 3'd6);
    zero = w ? (b[31:0] == 0) : (b == 0);
    ovf  = sgn && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                     : (a == MINV && b == ONES));
    if (o[2] && (zero || ovf)) return 1;
    return w ? 33 : 65;
  endfunction

  // Drive one request, then wait for out_valid counting edges from (and including) the accept edge.
  task automatic do_op(input string tag, input logic [2:0] o, input logic w,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int lat_exp);
    int lat;
    logic [63:0] e;
    int l;
    q_exp.push_back(exp);
    q_lat.push_back(lat_exp);
    check({tag, "_rdy"}, in_ready, 1);
    op = o; word = w; src_a = a; src_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    e = q_exp.pop_front();
    l = q_lat.pop_front();
    check({tag, "_lat"}, lat, l);
    check(tag, result, e);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_hs_ir"}, in_ready, 1);
    check({tag, "_hs_ov"}, out_valid, 0);
  endtask

  task automatic op_consume(input string tag, input logic [2:0] o, input logic w,
                            input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] exp, input int lat_exp);
    do_op(tag, o, w, a, b, exp, lat_exp);
    consume(tag);
  endtask

  task automatic start_div();
    op = 3'd4; word = 1'b0; src_a = 64'd1000; src_b = 64'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic expect_silence(input string tag);
    int seen;
    seen = 0;
    repeat (70) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; word = 1'b0; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ir", in_ready, 1);
    check("rst_ov", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_res", result, 0);

    op_consume("mul",    3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 65);
    op_consume("mulhu",  3'd3, 1'b0, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    op_consume("mulh",   3'd1, 1'b0, ONES, ONES, 64'd0, 65);
    op_consume("mulhsu", 3'd2, 1'b0, ONES, 64'd2, ONES, 65);
    op_consume("div",    3'd4, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    op_consume("rem",    3'd6, 1'b0, -64'sd7, 64'd2, ONES, 65);
    op_consume("divu",   3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65);
    op_consume("remu",   3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 65);
    op_consume("divu0",  3'd5, 1'b0, 64'h1234, 64'd0, ONES, 1);
    op_consume("remu0",  3'd7, 1'b0, 64'h1234, 64'd0, 64'h1234, 1);
    op_consume("divwov", 3'd4, 1'b1, 64'h1_8000_0000, ONES, 64'hFFFF_FFFF_8000_0000, 1);
    op_consume("remwov", 3'd6, 1'b1, 64'h1_8000_0000, ONES, 64'd0, 1);

    // result held while the consumer stalls
    do_op("hold", 3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65);
    repeat (10) begin
      @(posedge clk); #1;
      check("hold_ov", out_valid, 1);
      check("hold_res", result, 64'd14);
      check("hold_ir", in_ready, 0);
    end
    consume("hold");
    check("post_hs_res", result, 64'd14);

    // flush mid-divide
    start_div();
    check("calc_busy", busy, 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_ir", in_ready, 1);
    check("flush_res", result, 0);
    expect_silence("flush_noout");
    op_consume("mulw_f", 3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33);

    // reset mid-divide
    start_div();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst2_busy", busy, 0);
    check("rst2_ov", out_valid, 0);
    expect_silence("rst2_noout");
    op_consume("mulw_r", 3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33);

    // flush wins over a request in IDLE
    op = 3'd0; word = 1'b0; src_a = 64'd5; src_b = 64'd5; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_req_busy", busy, 0);

    // word forms of MULH* behave as MULW
    op_consume("mulhw", 3'd1, 1'b1, 64'hFFFF_FFFF, 64'h3, 64'hFFFF_FFFF_FFFF_FFFD, 33);

    // random mix, including divide-by-zero and overflow operands
    for (int i = 0; i < 24; i++) begin
      logic [2:0]  o;
      logic        w;
      logic [63:0] a, b;
      int          mode;
      o = 3'($urandom_range(0, 7));
      w = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      mode = $urandom_range(0, 5);
      if (mode == 0) b = w ? {b[63:32], 32'd0} : 64'd0;
      if (mode == 1) begin
        a = w ? {a[63:32], 32'h8000_0000} : MINV;
        b = w ? {b[63:32], 32'hFFFF_FFFF} : ONES;
      end
      if (mode == 2) b = {32'd0, 16'd0, b[15:0]};
      op_consume($sformatf("rnd%0d", i), o, w, a, b, ref_mdu(o, w, a, b), ref_lat(o, w, a, b));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
